// File: rtl/fwd_src_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_pipe_pkg
// Purpose  : Shared Tnew encodings, write-data source select and bubble tag
//            for the forwarding-source pipeline.
// Revision : 1.0  initial release
// ============================================================================
package fwd_src_pipe_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int TW_DEF = 2;

    localparam int TNEW_NOW = 0;
    localparam int TNEW_ALU = 1;
    localparam int TNEW_MEM = 2;

    typedef enum logic [1:0] {
        WD_SRC_ZERO = 2'd0,
        WD_SRC_NOW  = 2'd1,
        WD_SRC_NEW  = 2'd2
    } wd_src_e;

    typedef struct packed {
        logic              grfwe;
        logic [AW_DEF-1:0] addr;
        logic [TW_DEF-1:0] tnew;
        logic [DW_DEF-1:0] wd;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_tag_stage.sv
`default_nettype none
// ============================================================================
// Module   : fwd_tag_stage
// Purpose  : One pipeline register for a register-write tag, with hold,
//            bubble insertion, optional saturating Tnew decrement and a
//            write-data source select.
// Revision : 1.0  initial release
// ============================================================================
module fwd_tag_stage
    import fwd_src_pipe_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int TW  = TW_DEF,
    parameter bit DEC = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_hold,
    input  logic          i_bubble,
    input  logic          i_grfwe,
    input  logic [AW-1:0] i_addr,
    input  logic [TW-1:0] i_tnew,
    input  wd_src_e       i_wd_sel,
    input  logic [DW-1:0] i_wd_now,
    input  logic [DW-1:0] i_wd_new,
    output logic          o_grfwe,
    output logic [AW-1:0] o_addr,
    output logic [TW-1:0] o_tnew,
    output logic [DW-1:0] o_wd
);

    logic          r_grfwe;
    logic [AW-1:0] r_addr;
    logic [TW-1:0] r_tnew;
    logic [DW-1:0] r_wd;

    logic          w_grfwe;
    logic [TW-1:0] w_tnew;
    logic [DW-1:0] w_wd;

    // Writes to $0 are dropped here so no downstream consumer ever matches it.
    assign w_grfwe = i_grfwe && (i_addr != '0);

    always_comb begin
        w_tnew = i_tnew;
        if (DEC && (i_tnew != '0)) begin
            w_tnew = i_tnew - TW'(1);
        end
    end

    always_comb begin
        w_wd = '0;
        case (i_wd_sel)
            WD_SRC_NOW:  w_wd = i_wd_now;
            WD_SRC_NEW:  w_wd = i_wd_new;
            default:     w_wd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grfwe <= 1'b0;
            r_addr  <= '0;
            r_tnew  <= '0;
            r_wd    <= '0;
        end else if (i_hold) begin
            r_grfwe <= r_grfwe;
            r_addr  <= r_addr;
            r_tnew  <= r_tnew;
            r_wd    <= r_wd;
        end else if (i_bubble || !w_grfwe) begin
            r_grfwe <= BUBBLE_TAG.grfwe;
            r_addr  <= AW'(BUBBLE_TAG.addr);
            r_tnew  <= TW'(BUBBLE_TAG.tnew);
            r_wd    <= DW'(BUBBLE_TAG.wd);
        end else begin
            r_grfwe <= 1'b1;
            r_addr  <= i_addr;
            r_tnew  <= w_tnew;
            r_wd    <= w_wd;
        end
    end

    assign o_grfwe = r_grfwe;
    assign o_addr  = r_addr;
    assign o_tnew  = r_tnew;
    assign o_wd    = r_wd;

endmodule
`default_nettype wire

// File: rtl/fwd_src_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_pipe
// Purpose  : Producer side of the D-stage forwarding interface: carries
//            write tags through E/M/W and raises the Tuse/Tnew decode stall.
// Revision : 1.0  initial release
// ============================================================================
module fwd_src_pipe
    import fwd_src_pipe_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          D_GRFWE,
    input  logic [AW-1:0] D_Addr,
    input  logic [TW-1:0] D_Tnew,
    input  logic [DW-1:0] D_WD,
    input  logic [AW-1:0] D_Rs,
    input  logic [AW-1:0] D_Rt,
    input  logic          D_UseRs,
    input  logic          D_UseRt,
    input  logic [TW-1:0] D_TuseRs,
    input  logic [TW-1:0] D_TuseRt,
    input  logic [DW-1:0] E_ALUOut,
    input  logic [DW-1:0] M_DMOut,
    output logic          stall,
    output logic          E_GRFWE,
    output logic          M_GRFWE,
    output logic          W_GRFWE,
    output logic [AW-1:0] E_Addr,
    output logic [AW-1:0] M_Addr,
    output logic [AW-1:0] W_Addr,
    output logic [TW-1:0] E_Tnew,
    output logic [TW-1:0] M_Tnew,
    output logic [DW-1:0] E_WD,
    output logic [DW-1:0] M_WD,
    output logic [DW-1:0] W_WD
);

    wd_src_e       w_e_sel;
    wd_src_e       w_m_sel;
    wd_src_e       w_w_sel;
    logic [TW-1:0] w_w_tnew;
    logic          w_hz_rs;
    logic          w_hz_rt;

    function automatic logic f_hazard(
        input logic          grfwe,
        input logic [AW-1:0] addr,
        input logic [TW-1:0] tnew,
        input logic [AW-1:0] src,
        input logic          use_src,
        input logic [TW-1:0] tuse
    );
        return grfwe && (addr == src) && (src != '0) && use_src && (tnew > tuse);
    endfunction

    assign w_hz_rs = f_hazard(E_GRFWE, E_Addr, E_Tnew, D_Rs, D_UseRs, D_TuseRs)
                   | f_hazard(M_GRFWE, M_Addr, M_Tnew, D_Rs, D_UseRs, D_TuseRs);
    assign w_hz_rt = f_hazard(E_GRFWE, E_Addr, E_Tnew, D_Rt, D_UseRt, D_TuseRt)
                   | f_hazard(M_GRFWE, M_Addr, M_Tnew, D_Rt, D_UseRt, D_TuseRt);
    assign stall   = w_hz_rs | w_hz_rt;

    // Each stage takes its write data from whichever source has just produced it.
    always_comb begin
        w_e_sel = (D_Tnew == TW'(TNEW_NOW)) ? WD_SRC_NOW : WD_SRC_ZERO;
        if (E_Tnew == TW'(TNEW_NOW)) begin
            w_m_sel = WD_SRC_NOW;
        end else if (E_Tnew == TW'(TNEW_ALU)) begin
            w_m_sel = WD_SRC_NEW;
        end else begin
            w_m_sel = WD_SRC_ZERO;
        end
        w_w_sel = (M_Tnew == TW'(TNEW_ALU)) ? WD_SRC_NEW : WD_SRC_NOW;
    end

    fwd_tag_stage #(.AW(AW), .DW(DW), .TW(TW), .DEC(1'b0)) u_stage_e (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_hold   (hold),
        .i_bubble (flush | stall),
        .i_grfwe  (D_GRFWE),
        .i_addr   (D_Addr),
        .i_tnew   (D_Tnew),
        .i_wd_sel (w_e_sel),
        .i_wd_now (D_WD),
        .i_wd_new ({DW{1'b0}}),
        .o_grfwe  (E_GRFWE),
        .o_addr   (E_Addr),
        .o_tnew   (E_Tnew),
        .o_wd     (E_WD)
    );

    fwd_tag_stage #(.AW(AW), .DW(DW), .TW(TW), .DEC(1'b1)) u_stage_m (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_hold   (hold),
        .i_bubble (1'b0),
        .i_grfwe  (E_GRFWE),
        .i_addr   (E_Addr),
        .i_tnew   (E_Tnew),
        .i_wd_sel (w_m_sel),
        .i_wd_now (E_WD),
        .i_wd_new (E_ALUOut),
        .o_grfwe  (M_GRFWE),
        .o_addr   (M_Addr),
        .o_tnew   (M_Tnew),
        .o_wd     (M_WD)
    );

    fwd_tag_stage #(.AW(AW), .DW(DW), .TW(TW), .DEC(1'b1)) u_stage_w (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_hold   (hold),
        .i_bubble (1'b0),
        .i_grfwe  (M_GRFWE),
        .i_addr   (M_Addr),
        .i_tnew   (M_Tnew),
        .i_wd_sel (w_w_sel),
        .i_wd_now (M_WD),
        .i_wd_new (M_DMOut),
        .o_grfwe  (W_GRFWE),
        .o_addr   (W_Addr),
        .o_tnew   (w_w_tnew),
        .o_wd     (W_WD)
    );

    // A tag still waiting more than one cycle in M cannot be satisfied by W.
    a_m_tnew_legal: assert property (@(posedge clk) disable iff (!reset_n)
        M_Tnew <= TW'(TNEW_ALU));

    a_w_tnew_zero: assert property (@(posedge clk) disable iff (!reset_n)
        w_w_tnew == '0);

endmodule
`default_nettype wire

// File: tb/tb_fwd_src_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_src_pipe
// Purpose  : Directed self-checking bench for fwd_src_pipe.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_src_pipe;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          reset_n, hold, flush;
    logic          D_GRFWE, D_UseRs, D_UseRt;
    logic [AW-1:0] D_Addr, D_Rs, D_Rt;
    logic [TW-1:0] D_Tnew, D_TuseRs, D_TuseRt;
    logic [DW-1:0] D_WD, E_ALUOut, M_DMOut;
    logic          stall, E_GRFWE, M_GRFWE, W_GRFWE;
    logic [AW-1:0] E_Addr, M_Addr, W_Addr;
    logic [TW-1:0] E_Tnew, M_Tnew;
    logic [DW-1:0] E_WD, M_WD, W_WD;

    int checks   = 0;
    int failures = 0;

    fwd_src_pipe #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush(flush),
        .D_GRFWE(D_GRFWE), .D_Addr(D_Addr), .D_Tnew(D_Tnew), .D_WD(D_WD),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
        .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
        .E_ALUOut(E_ALUOut), .M_DMOut(M_DMOut), .stall(stall),
        .E_GRFWE(E_GRFWE), .M_GRFWE(M_GRFWE), .W_GRFWE(W_GRFWE),
        .E_Addr(E_Addr), .M_Addr(M_Addr), .W_Addr(W_Addr),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .E_WD(E_WD), .M_WD(M_WD), .W_WD(W_WD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        D_GRFWE = 0; D_Addr = 0; D_Tnew = 0; D_WD = 0;
        D_Rs = 0; D_Rt = 0; D_UseRs = 0; D_UseRt = 0; D_TuseRs = 0; D_TuseRt = 0;
    endtask

    task automatic set_tag(input logic we, input logic [AW-1:0] a,
                           input logic [TW-1:0] t, input logic [DW-1:0] wd);
        clear_d();
        D_GRFWE = we; D_Addr = a; D_Tnew = t; D_WD = wd;
    endtask

    task automatic idle(input int n);
        clear_d();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 0; hold = 0; flush = 0; E_ALUOut = 0; M_DMOut = 0;
        set_tag(1, 5'd7, 2'd2, 32'h55);
        tick(); tick();
        checks++; if ({E_GRFWE, M_GRFWE, W_GRFWE} !== 3'b000) begin failures++; $display("FAIL reset_we got=%b exp=000", {E_GRFWE, M_GRFWE, W_GRFWE}); end
        checks++; if ({E_Addr, M_Addr, W_Addr, E_Tnew, M_Tnew} !== '0) begin failures++; $display("FAIL reset_addr_tnew got=%h exp=0", {E_Addr, M_Addr, W_Addr, E_Tnew, M_Tnew}); end
        checks++; if ({E_WD, M_WD, W_WD} !== '0) begin failures++; $display("FAIL reset_wd got=%h exp=0", {E_WD, M_WD, W_WD}); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        reset_n = 1;
        idle(1);
    endtask

    task automatic test_alu_chain();
        set_tag(1, 5'd5, 2'd1, 32'hFFFF);
        tick();
        checks++; if ({E_GRFWE, E_Addr, E_Tnew, E_WD} !== {1'b1, 5'd5, 2'd1, 32'h0}) begin failures++; $display("FAIL alu_e got=%b/%0d/%0d/%h exp=1/5/1/0", E_GRFWE, E_Addr, E_Tnew, E_WD); end
        clear_d(); E_ALUOut = 32'h1234;
        tick();
        E_ALUOut = 32'h0;
        checks++; if ({M_GRFWE, M_Addr, M_Tnew, M_WD} !== {1'b1, 5'd5, 2'd0, 32'h1234}) begin failures++; $display("FAIL alu_m got=%b/%0d/%0d/%h exp=1/5/0/1234", M_GRFWE, M_Addr, M_Tnew, M_WD); end
        tick();
        checks++; if ({W_GRFWE, W_Addr, W_WD} !== {1'b1, 5'd5, 32'h1234}) begin failures++; $display("FAIL alu_w got=%b/%0d/%h exp=1/5/1234", W_GRFWE, W_Addr, W_WD); end
        idle(3);
    endtask

    task automatic test_load_use();
        set_tag(1, 5'd8, 2'd2, 32'h0);
        tick();
        checks++; if (E_Tnew !== 2'd2) begin failures++; $display("FAIL lw_e_tnew got=%0d exp=2", E_Tnew); end
        set_tag(1, 5'd9, 2'd1, 32'h0);
        D_Rs = 5'd8; D_UseRs = 1; D_TuseRs = 2'd1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_clear got=%b exp=0", stall); end
        checks++; if ({E_GRFWE, E_Addr} !== {1'b0, 5'd0}) begin failures++; $display("FAIL lu_bubble got=%b/%0d exp=0/0", E_GRFWE, E_Addr); end
        checks++; if ({M_Addr, M_Tnew, M_WD} !== {5'd8, 2'd1, 32'h0}) begin failures++; $display("FAIL lu_m got=%0d/%0d/%h exp=8/1/0", M_Addr, M_Tnew, M_WD); end
        M_DMOut = 32'hCAFE;
        tick();
        M_DMOut = 32'h0;
        checks++; if ({W_GRFWE, W_Addr, W_WD} !== {1'b1, 5'd8, 32'hCAFE}) begin failures++; $display("FAIL lu_w got=%b/%0d/%h exp=1/8/cafe", W_GRFWE, W_Addr, W_WD); end
        checks++; if ({E_Addr, E_Tnew} !== {5'd9, 2'd1}) begin failures++; $display("FAIL lu_resume got=%0d/%0d exp=9/1", E_Addr, E_Tnew); end
        idle(3);
    endtask

    task automatic test_link();
        set_tag(1, 5'd31, 2'd0, 32'h3008);
        tick();
        checks++; if ({E_Addr, E_Tnew, E_WD} !== {5'd31, 2'd0, 32'h3008}) begin failures++; $display("FAIL link_e got=%0d/%0d/%h exp=31/0/3008", E_Addr, E_Tnew, E_WD); end
        clear_d(); E_ALUOut = 32'hDEAD;
        tick();
        E_ALUOut = 32'h0; M_DMOut = 32'hBEEF;
        checks++; if ({M_Tnew, M_WD} !== {2'd0, 32'h3008}) begin failures++; $display("FAIL link_m got=%0d/%h exp=0/3008", M_Tnew, M_WD); end
        tick();
        M_DMOut = 32'h0;
        checks++; if ({W_Addr, W_WD} !== {5'd31, 32'h3008}) begin failures++; $display("FAIL link_w got=%0d/%h exp=31/3008", W_Addr, W_WD); end
        idle(3);
    endtask

    task automatic test_zero_filter();
        set_tag(1, 5'd0, 2'd2, 32'h77);
        tick();
        checks++; if ({E_GRFWE, E_Tnew, E_WD} !== {1'b0, 2'd0, 32'h0}) begin failures++; $display("FAIL zero_e got=%b/%0d/%h exp=0/0/0", E_GRFWE, E_Tnew, E_WD); end
        clear_d(); D_Rs = 5'd0; D_UseRs = 1; D_TuseRs = 2'd0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", stall); end
        idle(3);
    endtask

    task automatic test_rt_hazard();
        set_tag(1, 5'd3, 2'd2, 32'h0);
        tick();
        clear_d();
        tick();
        D_Rt = 5'd3; D_UseRt = 1; D_TuseRt = 2'd0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rt_m_stall got=%b exp=1", stall); end
        D_TuseRt = 2'd1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rt_tuse_eq got=%b exp=0", stall); end
        D_TuseRt = 2'd0; D_UseRt = 0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rt_unused got=%b exp=0", stall); end
        idle(3);
    endtask

    task automatic test_hold_flush();
        set_tag(1, 5'd10, 2'd0, 32'hA); tick();
        set_tag(1, 5'd11, 2'd0, 32'hB); tick();
        set_tag(1, 5'd12, 2'd0, 32'hC); tick();
        set_tag(1, 5'd13, 2'd0, 32'hD);
        hold = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if ({E_Addr, M_Addr, W_Addr} !== {5'd12, 5'd11, 5'd10}) begin failures++; $display("FAIL hold_addr got=%0d/%0d/%0d exp=12/11/10", E_Addr, M_Addr, W_Addr); end
        checks++; if ({E_WD, M_WD, W_WD} !== {32'hC, 32'hB, 32'hA}) begin failures++; $display("FAIL hold_wd got=%h/%h/%h exp=c/b/a", E_WD, M_WD, W_WD); end
        hold = 0; flush = 1;
        tick();
        flush = 0;
        checks++; if ({E_GRFWE, E_Addr, E_WD} !== {1'b0, 5'd0, 32'h0}) begin failures++; $display("FAIL flush_e got=%b/%0d/%h exp=0/0/0", E_GRFWE, E_Addr, E_WD); end
        checks++; if ({M_Addr, M_WD, W_Addr, W_WD} !== {5'd12, 32'hC, 5'd11, 32'hB}) begin failures++; $display("FAIL flush_mw got=%0d/%h/%0d/%h exp=12/c/11/b", M_Addr, M_WD, W_Addr, W_WD); end
    endtask

    task automatic test_reset_mid();
        set_tag(1, 5'd20, 2'd2, 32'h0);
        tick();
        clear_d(); D_Rs = 5'd20; D_UseRs = 1; D_TuseRs = 2'd0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
        #1 reset_n = 0;
        #1;
        checks++; if ({E_GRFWE, M_GRFWE, W_GRFWE, E_Addr, M_Addr, W_Addr, E_Tnew, M_Tnew} !== '0) begin failures++; $display("FAIL mid_reset_tags got=%h exp=0", {E_GRFWE, M_GRFWE, W_GRFWE, E_Addr, M_Addr, W_Addr, E_Tnew, M_Tnew}); end
        checks++; if ({E_WD, M_WD, W_WD, stall} !== '0) begin failures++; $display("FAIL mid_reset_wd got=%h exp=0", {E_WD, M_WD, W_WD, stall}); end
        tick();
        reset_n = 1;
        idle(1);
    endtask

    initial begin
        clear_d();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_link();
        test_zero_filter();
        test_rt_hazard();
        test_hold_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
